// File: rtl/ram_pkg.sv
// Shared definitions for the on-chip RAM family: lane arithmetic, read-mode
// constants and the clear-sequencer state encoding.
package ram_pkg;

  localparam int CRdModeRdFirst = 0;
  localparam int CRdModeWrFirst = 1;

  typedef enum logic {
    IDLE = 1'b0,
    CLR  = 1'b1
  } tClrState;

  function automatic int laneCnt(input int dataLen, input int byteLen);
    return dataLen / byteLen;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Memory-clear sequencer: walks every address once, driving a zero-write
// address and a busy flag that the owning memory uses to block port writes.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int CAddrLen    = 11,
  parameter int CClrOnReset = 1
) (
  input  logic                AClk,
  input  logic                AReset,
  input  logic                AClkEn,
  input  logic                AClrReq,
  output logic                ABusy,
  output logic [CAddrLen-1:0] AClrAddr
);

  localparam tClrState            CRstState = (CClrOnReset != 0) ? CLR : IDLE;
  localparam logic [CAddrLen-1:0] COne      = CAddrLen'(1);

  tClrState            state, stateNxt;
  logic [CAddrLen-1:0] cnt, cntNxt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge AClk or posedge AReset) begin
    if (AReset) begin
      state <= CRstState;
      cnt   <= '0;
    end else if (AClkEn) begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    unique case (state)
      IDLE: begin
        if (AClrReq) begin
          stateNxt = CLR;
        end
      end
      CLR: begin
        cntNxt = cnt + COne;
        if (cnt == '1) begin
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign ABusy    = (state == CLR);
  assign AClrAddr = cnt;

endmodule

// File: rtl/ram_dp_be.sv
// True dual-port single-clock RAM with per-lane write enables, selectable
// read-during-write behaviour, optional output register and a clear sequencer.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter  int CAddrLen    = 11,
  parameter  int CDataLen    = 32,
  parameter  int CByteLen    = 8,
  parameter  int CRdMode     = 0,
  parameter  int COutReg     = 0,
  parameter  int CClrOnReset = 1,
  localparam int CLaneCnt    = laneCnt(CDataLen, CByteLen),
  localparam int CDepth      = 1 << CAddrLen
) (
  input  logic                AClk,
  input  logic                AReset,
  input  logic                AClkEn,
  input  logic                AClrReq,
  output logic                ABusy,
  input  logic [CAddrLen-1:0] AAddrA,
  input  logic [CDataLen-1:0] AMosiA,
  input  logic [CLaneCnt-1:0] AWrEnA,
  input  logic                ARdEnA,
  output logic [CDataLen-1:0] AMisoA,
  output logic                AMisoVldA,
  input  logic [CAddrLen-1:0] AAddrB,
  input  logic [CDataLen-1:0] AMosiB,
  input  logic [CLaneCnt-1:0] AWrEnB,
  input  logic                ARdEnB,
  output logic [CDataLen-1:0] AMisoB,
  output logic                AMisoVldB
);

  logic [CDataLen-1:0] mem [CDepth];
  logic [CAddrLen-1:0] clrAddr;
  logic [CDataLen-1:0] rdWordA, rdWordB;
  logic                rdAccA, rdAccB;
  logic                s1VldA, s1VldB;
  logic [CDataLen-1:0] s1DataA, s1DataB;

  ram_clr_seq #(
    .CAddrLen    (CAddrLen),
    .CClrOnReset (CClrOnReset)
  ) uClrSeq (
    .AClk     (AClk),
    .AReset   (AReset),
    .AClkEn   (AClkEn),
    .AClrReq  (AClrReq),
    .ABusy    (ABusy),
    .AClrAddr (clrAddr)
  );

  // NOTE: the array has no reset; zeroing is the sequencer's job so it still maps to block RAM.
  // Port A is assigned after port B, so it wins on lanes both enable at one address.
  always_ff @(posedge AClk) begin
    if (AClkEn) begin
      if (ABusy) begin
        mem[clrAddr] <= '0;
      end else begin
        for (int i = 0; i < CLaneCnt; i++) begin
          if (AWrEnB[i]) mem[AAddrB][i*CByteLen +: CByteLen] <= AMosiB[i*CByteLen +: CByteLen];
          if (AWrEnA[i]) mem[AAddrA][i*CByteLen +: CByteLen] <= AMosiA[i*CByteLen +: CByteLen];
        end
      end
    end
  end

  // Write-first forwards this cycle's merged write lanes onto the stored word.
  always_comb begin
    rdWordA = mem[AAddrA];
    rdWordB = mem[AAddrB];
    if (CRdMode == CRdModeWrFirst) begin
      for (int i = 0; i < CLaneCnt; i++) begin
        if (AWrEnB[i] && (AAddrB == AAddrA)) rdWordA[i*CByteLen +: CByteLen] = AMosiB[i*CByteLen +: CByteLen];
        if (AWrEnA[i])                       rdWordA[i*CByteLen +: CByteLen] = AMosiA[i*CByteLen +: CByteLen];
        if (AWrEnB[i])                       rdWordB[i*CByteLen +: CByteLen] = AMosiB[i*CByteLen +: CByteLen];
        if (AWrEnA[i] && (AAddrA == AAddrB)) rdWordB[i*CByteLen +: CByteLen] = AMosiA[i*CByteLen +: CByteLen];
      end
    end
  end

  assign rdAccA = ARdEnA & ~ABusy;
  assign rdAccB = ARdEnB & ~ABusy;

  always_ff @(posedge AClk or posedge AReset) begin
    if (AReset) begin
      s1VldA  <= 1'b0;
      s1VldB  <= 1'b0;
      s1DataA <= '0;
      s1DataB <= '0;
    end else if (AClkEn) begin
      s1VldA  <= rdAccA;
      s1VldB  <= rdAccB;
      s1DataA <= rdAccA ? rdWordA : '0;
      s1DataB <= rdAccB ? rdWordB : '0;
    end
  end

  generate
    if (COutReg != 0) begin : gOutReg
      logic                s2VldA, s2VldB;
      logic [CDataLen-1:0] s2DataA, s2DataB;

      always_ff @(posedge AClk or posedge AReset) begin
        if (AReset) begin
          s2VldA  <= 1'b0;
          s2VldB  <= 1'b0;
          s2DataA <= '0;
          s2DataB <= '0;
        end else if (AClkEn) begin
          s2VldA  <= s1VldA;
          s2VldB  <= s1VldB;
          s2DataA <= s1DataA;
          s2DataB <= s1DataB;
        end
      end

      assign AMisoVldA = s2VldA;
      assign AMisoVldB = s2VldB;
      assign AMisoA    = s2DataA;
      assign AMisoB    = s2DataB;
    end else begin : gNoOutReg
      assign AMisoVldA = s1VldA;
      assign AMisoVldB = s1VldB;
      assign AMisoA    = s1DataA;
      assign AMisoB    = s1DataB;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_be.sv
// Self-checking bench: four ram_dp_be instances (read mode x output register)
// share stimulus and are compared every cycle against a word-level model.
module tb_ram_dp_be;

  localparam int CAddrLen = 4;
  localparam int CDataLen = 32;
  localparam int CLaneCnt = 4;
  localparam int CDepth   = 16;

  logic                AClk = 1'b0;
  logic                AReset, AClkEn, AClrReq;
  logic [CAddrLen-1:0] AAddrA, AAddrB;
  logic [CDataLen-1:0] AMosiA, AMosiB;
  logic [CLaneCnt-1:0] AWrEnA, AWrEnB;
  logic                ARdEnA, ARdEnB;

  // Instance g: read mode = g/2, output register = g%2.
  logic [CDataLen-1:0] misoA [4];
  logic [CDataLen-1:0] misoB [4];
  logic                vldA  [4];
  logic                vldB  [4];
  logic                busy  [4];

  always #5 AClk = ~AClk;

  for (genvar g = 0; g < 4; g++) begin : gDut
    ram_dp_be #(
      .CAddrLen    (CAddrLen),
      .CDataLen    (CDataLen),
      .CByteLen    (8),
      .CRdMode     (g / 2),
      .COutReg     (g % 2),
      .CClrOnReset (1)
    ) uDut (
      .AClk      (AClk),
      .AReset    (AReset),
      .AClkEn    (AClkEn),
      .AClrReq   (AClrReq),
      .ABusy     (busy[g]),
      .AAddrA    (AAddrA),
      .AMosiA    (AMosiA),
      .AWrEnA    (AWrEnA),
      .ARdEnA    (ARdEnA),
      .AMisoA    (misoA[g]),
      .AMisoVldA (vldA[g]),
      .AAddrB    (AAddrB),
      .AMosiB    (AMosiB),
      .AWrEnB    (AWrEnB),
      .ARdEnB    (ARdEnB),
      .AMisoB    (misoB[g]),
      .AMisoVldB (vldB[g])
    );
  end

  int tests = 0;
  int fails = 0;

  // Reference model: plain word array, clear progress, and per-mode read pipeline.
  logic [CDataLen-1:0] mMem [CDepth];
  logic                mBusy;
  int                  mIdx;
  logic                pV [2][2][2];   // [stage][mode][port]
  logic [CDataLen-1:0] pD [2][2][2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [CDataLen-1:0] postWrite(input logic [CAddrLen-1:0] addr);
    logic [CDataLen-1:0] w;
    w = mMem[addr];
    for (int l = 0; l < CLaneCnt; l++) begin
      if (AWrEnB[l] && AAddrB == addr) w[l*8 +: 8] = AMosiB[l*8 +: 8];
      if (AWrEnA[l] && AAddrA == addr) w[l*8 +: 8] = AMosiA[l*8 +: 8];
    end
    return w;
  endfunction

  task automatic modelReset();
    mBusy = 1'b1;
    mIdx  = 0;
    for (int s = 0; s < 2; s++)
      for (int m = 0; m < 2; m++)
        for (int p = 0; p < 2; p++) begin
          pV[s][m][p] = 1'b0;
          pD[s][m][p] = '0;
        end
  endtask

  task automatic modelStep();
    logic [CDataLen-1:0] rd [2][2];
    logic                acc [2];
    if (AReset) begin
      modelReset();
    end else if (AClkEn) begin
      acc[0]   = ARdEnA && !mBusy;
      acc[1]   = ARdEnB && !mBusy;
      rd[0][0] = mMem[AAddrA];
      rd[0][1] = mMem[AAddrB];
      rd[1][0] = postWrite(AAddrA);
      rd[1][1] = postWrite(AAddrB);
      for (int m = 0; m < 2; m++)
        for (int p = 0; p < 2; p++) begin
          pV[1][m][p] = pV[0][m][p];
          pD[1][m][p] = pD[0][m][p];
          pV[0][m][p] = acc[p];
          pD[0][m][p] = acc[p] ? rd[m][p] : '0;
        end
      if (mBusy) begin
        mMem[mIdx] = '0;
        if (mIdx == CDepth - 1) begin
          mBusy = 1'b0;
          mIdx  = 0;
        end else begin
          mIdx++;
        end
      end else begin
        for (int l = 0; l < CLaneCnt; l++) begin
          if (AWrEnB[l]) mMem[AAddrB][l*8 +: 8] = AMosiB[l*8 +: 8];
          if (AWrEnA[l]) mMem[AAddrA][l*8 +: 8] = AMosiA[l*8 +: 8];
        end
        if (AClrReq) begin
          mBusy = 1'b1;
          mIdx  = 0;
        end
      end
    end
  endtask

  // Advance one clock: the model steps on the same edge as the DUTs, inputs change 2ns later.
  task automatic tick();
    @(posedge AClk);
    modelStep();
    #2;
  endtask

  task automatic idleInputs();
    AClrReq = 1'b0;
    AAddrA  = '0;
    AAddrB  = '0;
    AMosiA  = '0;
    AMosiB  = '0;
    AWrEnA  = '0;
    AWrEnB  = '0;
    ARdEnA  = 1'b0;
    ARdEnB  = 1'b0;
  endtask

  // Cycle-by-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge AClk);
      for (int g = 0; g < 4; g++) begin
        check($sformatf("cyc g%0d busy", g), 32'(busy[g]), 32'(mBusy));
        check($sformatf("cyc g%0d vldA", g), 32'(vldA[g]), 32'(pV[g % 2][g / 2][0]));
        check($sformatf("cyc g%0d vldB", g), 32'(vldB[g]), 32'(pV[g % 2][g / 2][1]));
        check($sformatf("cyc g%0d misoA", g), misoA[g], pD[g % 2][g / 2][0]);
        check($sformatf("cyc g%0d misoB", g), misoB[g], pD[g % 2][g / 2][1]);
      end
    end
  end

  initial begin
    int n;
    AReset = 1'b1;
    AClkEn = 1'b1;
    idleInputs();
    modelReset();
    tick();
    tick();
    check("rst busy", 32'(busy[0]), 32'd1);
    check("rst vldA", 32'(vldA[0]), 32'd0);
    check("rst misoA", misoA[0], 32'd0);

    // Power-up clear must hold busy for exactly one pass over all 16 words.
    AReset = 1'b0;
    n = 0;
    while (busy[0] === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("init clr cycles", 32'(n), 32'd16);

    ARdEnA = 1'b1;
    for (int a = 0; a < CDepth; a++) begin
      AAddrA = CAddrLen'(a);
      tick();
      check($sformatf("zero rd %0d vld", a), 32'(vldA[0]), 32'd1);
      check($sformatf("zero rd %0d data", a), misoA[0], 32'd0);
    end
    idleInputs();
    tick();

    // Lane merge over two writes.
    AAddrA = 4'd3; AMosiA = 32'hAABBCCDD; AWrEnA = 4'hF;
    tick();
    AMosiA = 32'h11223344; AWrEnA = 4'h2;
    tick();
    AWrEnA = '0; ARdEnA = 1'b1;
    tick();
    ARdEnA = 1'b0;
    check("model mem3", mMem[3], 32'hAABB33DD);
    check("lane merge g0", misoA[0], 32'hAABB33DD);
    check("outreg N+1 vld", 32'(vldA[1]), 32'd0);
    tick();
    check("outreg N+2 vld", 32'(vldA[1]), 32'd1);
    check("outreg N+2 data", misoA[1], 32'hAABB33DD);

    // Same-address collision, A owns shared lanes.
    AAddrA = 4'd5; AMosiA = 32'h11111111; AWrEnA = 4'h3;
    AAddrB = 4'd5; AMosiB = 32'h22222222; AWrEnB = 4'hE;
    tick();
    idleInputs();
    AAddrA = 4'd5; ARdEnA = 1'b1; AAddrB = 4'd5; ARdEnB = 1'b1;
    tick();
    idleInputs();
    check("model mem5", mMem[5], 32'h22221111);
    check("collision A", misoA[0], 32'h22221111);
    check("collision B", misoB[0], 32'h22221111);

    // Read-during-write: old word vs new word.
    AAddrA = 4'd7; AMosiA = 32'h5; AWrEnA = 4'hF;
    tick();
    idleInputs();
    AAddrA = 4'd7; ARdEnA = 1'b1;
    AAddrB = 4'd7; AMosiB = 32'h9; AWrEnB = 4'hF;
    tick();
    idleInputs();
    check("rd-first", misoA[0], 32'h5);
    check("wr-first", misoA[2], 32'h9);
    tick();
    check("rd-first outreg", misoA[1], 32'h5);
    check("wr-first outreg", misoA[3], 32'h9);

    // Clock-enable stall while a registered read is in flight.
    AAddrA = 4'd5; ARdEnA = 1'b1;
    tick();
    ARdEnA = 1'b0; AClkEn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall %0d vld", k), 32'(vldA[1]), 32'd0);
    end
    AClkEn = 1'b1;
    tick();
    check("stall end vld", 32'(vldA[1]), 32'd1);
    check("stall end data", misoA[1], 32'h22221111);
    tick();

    // Clear request, dropped write and read while busy, then reset at step 6.
    AClrReq = 1'b1;
    tick();
    AClrReq = 1'b0;
    check("clr busy rise", 32'(busy[0]), 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        AAddrA = 4'd14; AMosiA = 32'hDEADBEEF; AWrEnA = 4'hF; ARdEnB = 1'b1; AAddrB = 4'd5;
      end else begin
        idleInputs();
      end
      tick();
      if (k == 4) begin
        check("busy rd vld", 32'(vldB[0]), 32'd0);
        check("busy rd data", misoB[0], 32'd0);
      end
    end
    idleInputs();
    AReset = 1'b1;
    modelReset();
    #1;
    check("mid-clr rst busy", 32'(busy[0]), 32'd1);
    tick();
    AReset = 1'b0;
    n = 0;
    while (busy[0] === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("restart clr cycles", 32'(n), 32'd16);
    AAddrA = 4'd14; ARdEnA = 1'b1;
    tick();
    idleInputs();
    check("dropped write", misoA[0], 32'd0);
    check("dropped vld", 32'(vldA[0]), 32'd1);

    // Randomised traffic with dense address collisions.
    for (int c = 0; c < 1500; c++) begin
      AAddrA  = CAddrLen'($urandom_range(0, CDepth - 1));
      AAddrB  = CAddrLen'($urandom_range(0, CDepth - 1));
      AMosiA  = $urandom;
      AMosiB  = $urandom;
      AWrEnA  = ($urandom_range(0, 2) == 0) ? CLaneCnt'($urandom) : '0;
      AWrEnB  = ($urandom_range(0, 2) == 0) ? CLaneCnt'($urandom) : '0;
      ARdEnA  = 1'($urandom);
      ARdEnB  = 1'($urandom);
      AClkEn  = ($urandom_range(0, 7) != 0);
      AClrReq = ($urandom_range(0, 149) == 0);
      tick();
    end
    idleInputs();
    AClkEn = 1'b1;
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
- Single-clock, true dual-port synchronous RAM with per-byte write enables and a selectable read-during-write mode.
- Deterministic collision resolution between the two ports, an optional output pipeline register, and a built-in memory-clear sequencer.
- Parametrised successor of the existing dual-port RAM model; used as the generic on-chip data/scratch memory for core and peripheral subsystems.
- Synthesisable and simulation-exact.

Parameters:
- CAddrLen, 11: address width; depth = 2^CAddrLen words.
- CDataLen, 32: word width; must be a multiple of CByteLen.
- CByteLen, 8: lane width; lane count CLaneCnt = CDataLen/CByteLen.
- CRdMode, 0: 0 = read-first (old data), 1 = write-first (new data).
- COutReg, 0: 1 adds one output register stage.
- CClrOnReset, 1: 1 clears all memory after reset release.

Ports:
- AClk  in  1  clock, rising edge.
- AReset  in  1  asynchronous reset, active-high.
- AClkEn  in  1  global clock enable; low freezes every register, FSM and memory.
- AClrReq  in  1  single-cycle request to clear the whole memory.
- ABusy  out  1  clear sequence in progress.
- AAddrA  in  CAddrLen  port A address.
- AMosiA  in  CDataLen  port A write data.
- AWrEnA  in  CLaneCnt  port A per-lane write enable.
- ARdEnA  in  1  port A read request.
- AMisoA  out  CDataLen  port A read data.
- AMisoVldA  out  1  port A read data valid.
- AAddrB, AMosiB, AWrEnB, ARdEnB, AMisoB, AMisoVldB: same as port A, for port B.

Behaviour:
- Reset (async assert): AMisoA/B = 0, AMisoVldA/B = 0, pipeline stages cleared, clear counter = 0. FSM enters CLR if CClrOnReset = 1, else IDLE. ABusy reflects FSM state immediately. Memory contents are not reset asynchronously.
- Qualification: all behaviour below applies only on cycles with AClkEn = 1; otherwise state holds.
- FSM states: IDLE, CLR.
  - IDLE -> CLR when AClrReq = 1; ABusy rises the next cycle.
  - In CLR: writes 0 to mem[counter] each cycle, counter increments. After writing address 2^CAddrLen-1, counter wraps to 0 and FSM returns to IDLE. A clear takes exactly 2^CAddrLen cycles.
  - AClrReq while in CLR is ignored.
  - AReset mid-clear restarts per the reset rule above.
- While ABusy = 1: port writes are dropped; reads are accepted but return AMiso = 0 with AMisoVld = 0.
- Write: for each lane i with AWrEn?[i] = 1, mem[addr][lane i] <= AMosi?[lane i]. Other lanes are unchanged. AWrEn = 0 means no write.
- Read latency: 1 cycle (COutReg = 0) or 2 cycles (COutReg = 1) from the ARdEn cycle to AMisoVld.
  - AMisoVld is a pure delayed copy of ARdEn (gated by not-busy at request time).
  - AMiso = 0 whenever AMisoVld = 0.
- Same-cycle write collision, same address: port A wins on lanes enabled by both ports; lanes enabled only by B take B's data.
- Read of an address written in the same cycle, by the same or the other port:
  - CRdMode = 0: returns the pre-write word.
  - CRdMode = 1: returns the post-write word, after collision resolution and lane merging.
- Reads on both ports of the same address are always permitted and return identical data.
- Address wrap: none needed; all addresses are in range by construction.

Decomposition:
- Shared package ram_pkg holds:
  - lane-count function (CDataLen/CByteLen);
  - read-mode constants CRdModeRdFirst = 0 and CRdModeWrFirst = 1;
  - FSM state encoding (IDLE = 0, CLR = 1).
- One natural sub-module: ram_clr_seq (FSM, counter and ABusy), reusable by other memories.
- Collision merge logic and storage array stay in ram_dp_be.

Test Plan:
- CClrOnReset = 1, CAddrLen = 4: release reset -> ABusy high exactly 16 cycles. Then read every address -> all 0x00000000, AMisoVld 1 cycle after ARdEn.
- Write A addr 3 = 0xAABBCCDD with AWrEnA = 0xF, then AWrEnA = 0x2 with data 0x11223344 -> read returns 0xAABB33DD.
- Same cycle: A writes addr 5 = 0x11111111 with lanes 0x3; B writes addr 5 = 0x22222222 with lanes 0xE -> mem[5] = 0x22221111.
- CRdMode = 0 vs 1: mem[7] = 0x5; same cycle B writes 0x9 to addr 7 while A reads addr 7 -> AMisoA = 0x5 (mode 0) or 0x9 (mode 1).
- COutReg = 1: read issued at cycle N -> AMisoVld at N+2. Hold AClkEn low 3 cycles mid-flight -> valid delayed by exactly 3 cycles, data unchanged.
- Assert AClrReq, then AReset at clear step 6 -> ABusy stays high; full clear restarts from address 0. A write during busy is dropped, so that address reads 0 afterwards.
